// File: rtl/tiny_dnn_pkg.sv
// Shared types and widths for the tiny DNN dot-product sequencer.
package tiny_dnn_pkg;

  localparam int DATA_W     = 16;
  localparam int ACC_W      = 32;
  localparam int ADDR_W_DEF = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_W  = 3'd1,
    ST_RD_X  = 3'd2,
    ST_MAC   = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

endpackage

// File: rtl/tiny_dnn_mac.sv
// 16x16 unsigned multiply-accumulate into a 32-bit accumulator that wraps.
module tiny_dnn_mac
  import tiny_dnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] x,
  input  logic              en,
  input  logic              clr,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod;

  // Widen both operands first; a self-determined w*x would keep only 16 bits.
  assign prod = ACC_W'(w) * ACC_W'(x);

  always_comb begin
    // NOTE: default first so every path assigns acc_d and no latch is inferred.
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/tiny_dnn_mac_seq.sv
// Dot-product sequencer: streams two vectors from the shared RAM through the MAC
// and writes the shifted sum back; the host gets the RAM port whenever idle.
module tiny_dnn_mac_seq
  import tiny_dnn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = 10,
  parameter int SHIFT  = 0
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_waddr,
  input  logic [ADDR_W-1:0] cmd_xaddr,
  input  logic [ADDR_W-1:0] cmd_oaddr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              host_req,
  output logic              host_gnt,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, xaddr_q, xaddr_d, oaddr_q, oaddr_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_shr;
  logic              accept, mac_en, last_elem;

  // The host wins the port in IDLE; a pending command just waits for it to drop.
  assign host_gnt  = host_req && (state_q == ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE) && !host_req;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != ST_IDLE);
  assign mac_en    = (state_q == ST_MAC);
  assign last_elem = (idx_q == len_q - LEN_W'(1));
  assign acc_shr   = acc >> SHIFT;
  assign result    = result_q;

  tiny_dnn_mac u_mac (
    .clk  (S_AXI_ACLK),
    .rst_n(S_AXI_ARESETN),
    .w    (w_q),
    .x    (ram_rdata),
    .en   (mac_en),
    .clr  (accept),
    .acc  (acc)
  );

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    xaddr_d  = xaddr_q;
    oaddr_d  = oaddr_q;
    len_d    = len_q;
    idx_d    = idx_q;
    w_d      = w_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          waddr_d = cmd_waddr;
          xaddr_d = cmd_xaddr;
          oaddr_d = cmd_oaddr;
          len_d   = cmd_len;
          idx_d   = '0;
          state_d = (cmd_len == '0) ? ST_WRITE : ST_RD_W;
        end
      end
      ST_RD_W: state_d = ST_RD_X;
      ST_RD_X: begin
        w_d     = ram_rdata;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        idx_d   = idx_q + LEN_W'(1);
        state_d = last_elem ? ST_WRITE : ST_RD_W;
      end
      ST_WRITE: begin
        result_d = acc;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address sums wrap naturally at ADDR_W bits.
  always_comb begin
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    done      = 1'b0;
    case (state_q)
      ST_RD_W: begin
        ram_re   = 1'b1;
        ram_addr = waddr_q + ADDR_W'(idx_q);
      end
      ST_RD_X: begin
        ram_re   = 1'b1;
        ram_addr = xaddr_q + ADDR_W'(idx_q);
      end
      ST_WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = oaddr_q;
        ram_wdata = acc_shr[DATA_W-1:0];
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= ST_IDLE;
      waddr_q  <= '0;
      xaddr_q  <= '0;
      oaddr_q  <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      w_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      xaddr_q  <= xaddr_d;
      oaddr_q  <= oaddr_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      w_q      <= w_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_tiny_dnn_mac_seq.sv
// Self-checking bench: RAM model plus a dot-product reference computed from the RAM
// contents, directed corner cases and randomized commands; SHIFT=0 and SHIFT=16 DUTs.
module tb_tiny_dnn_mac_seq;

  localparam int ADDR_W = 13;
  localparam int LEN_W  = 10;
  localparam int DEPTH  = 8192;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [ADDR_W-1:0] cmd_waddr = '0, cmd_xaddr = '0, cmd_oaddr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              host_req = 1'b0;

  logic              cmd_ready, host_gnt, ram_re, ram_we, busy, done;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_rdata, ram_wdata;
  logic [31:0]       result;

  logic              s16_cmd_ready, s16_host_gnt, s16_ram_re, s16_ram_we, s16_busy, s16_done;
  logic [ADDR_W-1:0] s16_ram_addr;
  logic [15:0]       s16_ram_wdata;
  logic [31:0]       s16_result;

  logic [15:0]       mem [0:DEPTH-1];

  int                n_checks = 0;
  int                n_fail = 0;
  int                n_wr = 0, n_rd = 0, n_bad = 0, n_ready_busy = 0;
  logic [ADDR_W-1:0] rd_log[$];

  always #5 clk = ~clk;

  tiny_dnn_mac_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .SHIFT(0)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_waddr(cmd_waddr), .cmd_xaddr(cmd_xaddr), .cmd_oaddr(cmd_oaddr), .cmd_len(cmd_len),
    .host_req(host_req), .host_gnt(host_gnt),
    .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .result(result)
  );

  tiny_dnn_mac_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .SHIFT(16)) dut_s16 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(s16_cmd_ready),
    .cmd_waddr(cmd_waddr), .cmd_xaddr(cmd_xaddr), .cmd_oaddr(cmd_oaddr), .cmd_len(cmd_len),
    .host_req(host_req), .host_gnt(s16_host_gnt),
    .ram_re(s16_ram_re), .ram_addr(s16_ram_addr), .ram_rdata(ram_rdata),
    .ram_we(s16_ram_we), .ram_wdata(s16_ram_wdata),
    .busy(s16_busy), .done(s16_done), .result(s16_result)
  );

  // Single-port RAM, one-cycle read latency, driven by the SHIFT=0 instance.
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // Protocol monitor, sampled just after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (ram_we) n_wr++;
    if (ram_re) begin
      n_rd++;
      rd_log.push_back(ram_addr);
    end
    if (ram_re && ram_we) n_bad++;
    if (host_gnt && (ram_re || ram_we || busy)) n_bad++;
    if (cmd_ready && busy) n_ready_busy++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_dot(input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] xa,
                                          input logic [LEN_W-1:0] len);
    logic [31:0] s = 32'd0;
    for (int k = 0; k < int'(len); k++)
      s = s + 32'(mem[(int'(wa) + k) % DEPTH]) * 32'(mem[(int'(xa) + k) % DEPTH]);
    return s;
  endfunction

  task automatic load_vec(input logic [ADDR_W-1:0] base, input int len, input bit rnd, input logic [15:0] val);
    for (int k = 0; k < len; k++)
      mem[(int'(base) + k) % DEPTH] <= rnd ? 16'($urandom) : val;
  endtask

  // Called one falling edge after the accept edge; returns cycles until done.
  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (!done && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 4000) check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_cmd(input string tag, input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] xa,
                         input logic [ADDR_W-1:0] oa, input logic [LEN_W-1:0] len);
    logic [31:0] exp;
    int          waitc, lat;
    @(negedge clk);
    exp = ref_dot(wa, xa, len);
    n_wr = 0;
    n_rd = 0;
    rd_log.delete();
    cmd_waddr = wa;
    cmd_xaddr = xa;
    cmd_oaddr = oa;
    cmd_len   = len;
    cmd_valid = 1'b1;
    #1;
    waitc = 0;
    while (!cmd_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 100) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_waddr = ADDR_W'($urandom);
    cmd_xaddr = ADDR_W'($urandom);
    cmd_oaddr = ADDR_W'($urandom);
    cmd_len   = LEN_W'($urandom);
    wait_done(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(3 * int'(len) + 1));
    check({tag, "_waddr"}, 32'(ram_addr), 32'(oa));
    check({tag, "_wdata"}, 32'(ram_wdata), {16'd0, exp[15:0]});
    check({tag, "_wdata_s16"}, 32'(s16_ram_wdata), {16'd0, exp[31:16]});
    @(negedge clk);
    #2;
    check({tag, "_result"}, result, exp);
    check({tag, "_result_s16"}, s16_result, exp);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_nwr"}, 32'(n_wr), 32'd1);
    check({tag, "_nrd"}, 32'(n_rd), 32'(2 * int'(len)));
    check({tag, "_mem"}, 32'(mem[oa]), {16'd0, exp[15:0]});
  endtask

  initial begin
    logic [31:0] exp_a, exp_b;
    int          lat;

    for (int a = 0; a < DEPTH; a++) mem[a] <= 16'd0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {26'd0, busy, done, ram_re, ram_we, host_gnt, cmd_ready}, 32'b000001);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;

    // Worked example: 1*4 + 2*5 + 3*6 = 32.
    mem[13'h010] <= 16'd1; mem[13'h011] <= 16'd2; mem[13'h012] <= 16'd3;
    mem[13'h020] <= 16'd4; mem[13'h021] <= 16'd5; mem[13'h022] <= 16'd6;
    run_cmd("ex3", 13'h010, 13'h020, 13'h030, 10'd3);
    check("ex3_result_const", result, 32'd32);
    check("ex3_mem_const", 32'(mem[13'h030]), 32'd32);

    run_cmd("len0", 13'h100, 13'h200, 13'h040, 10'd0);
    check("len0_mem_const", 32'(mem[13'h040]), 32'd0);

    load_vec(13'h100, 2, 1'b0, 16'hFFFF);
    load_vec(13'h200, 2, 1'b0, 16'hFFFF);
    run_cmd("wrap32", 13'h100, 13'h200, 13'h300, 10'd2);
    check("wrap32_result_const", result, 32'hFFFC0002);
    check("wrap32_s16_mem_const", 32'(s16_ram_wdata), 32'd0);

    load_vec(13'h1FFF, 2, 1'b1, 16'd0);
    load_vec(13'h0400, 2, 1'b1, 16'd0);
    run_cmd("awrap", 13'h1FFF, 13'h0400, 13'h0500, 10'd2);
    check("awrap_nreads", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() >= 4) begin
      check("awrap_w0_addr", 32'(rd_log[0]), 32'h1FFF);
      check("awrap_w1_addr", 32'(rd_log[2]), 32'h0000);
    end

    // Contention: host and command together in IDLE, host wins.
    load_vec(13'h0600, 4, 1'b1, 16'd0);
    load_vec(13'h0700, 4, 1'b1, 16'd0);
    load_vec(13'h0800, 3, 1'b1, 16'd0);
    load_vec(13'h0900, 3, 1'b1, 16'd0);
    @(negedge clk);
    exp_a = ref_dot(13'h0600, 13'h0700, 10'd4);
    exp_b = ref_dot(13'h0800, 13'h0900, 10'd3);
    host_req  = 1'b1;
    cmd_valid = 1'b1;
    cmd_waddr = 13'h0600; cmd_xaddr = 13'h0700; cmd_oaddr = 13'h0A00; cmd_len = 10'd4;
    #1;
    check("cont_idle_gnt", 32'(host_gnt), 32'd1);
    check("cont_idle_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("cont_host_blocks", 32'(busy), 32'd0);
    host_req = 1'b0;
    @(negedge clk);
    // Second command stays pending while A runs; host asks for the port meanwhile.
    cmd_waddr = 13'h0800; cmd_xaddr = 13'h0900; cmd_oaddr = 13'h0B00; cmd_len = 10'd3;
    host_req = 1'b1;
    #1;
    check("cont_busy_ready", {30'd0, busy, cmd_ready}, 32'b10);
    check("cont_busy_gnt", 32'(host_gnt), 32'd0);
    wait_done("cont_a", lat);
    check("cont_a_latency", 32'(lat), 32'd13);
    check("cont_a_wdata", 32'(ram_wdata), {16'd0, exp_a[15:0]});
    @(negedge clk);
    #1;
    check("cont_after_gnt", 32'(host_gnt), 32'd1);
    check("cont_after_ready", 32'(cmd_ready), 32'd0);
    check("cont_a_result", result, exp_a);
    host_req = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cont_b_accepted", 32'(busy), 32'd1);
    wait_done("cont_b", lat);
    check("cont_b_latency", 32'(lat), 32'd10);
    check("cont_b_waddr", 32'(ram_addr), 32'h0B00);
    check("cont_b_wdata", 32'(ram_wdata), {16'd0, exp_b[15:0]});

    // Reset asserted while in MAC of a len=4 operation.
    load_vec(13'h0C00, 4, 1'b1, 16'd0);
    load_vec(13'h0D00, 4, 1'b1, 16'd0);
    @(negedge clk);
    @(negedge clk);
    cmd_waddr = 13'h0C00; cmd_xaddr = 13'h0D00; cmd_oaddr = 13'h0E00; cmd_len = 10'd4;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rmac_in_mac", {29'd0, busy, ram_re, ram_we}, 32'b100);
    n_wr = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rmac_outputs", {28'd0, busy, done, ram_re, ram_we}, 32'd0);
    check("rmac_result", result, 32'd0);
    check("rmac_result_s16", s16_result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #2;
    check("rmac_no_write", 32'(n_wr), 32'd0);
    run_cmd("rmac_after", 13'h0C00, 13'h0D00, 13'h0E00, 10'd4);

    // Randomized commands, addresses anywhere (including wrap).
    for (int t = 0; t < 14; t++) begin
      logic [ADDR_W-1:0] wa, xa, oa;
      logic [LEN_W-1:0]  len;
      wa  = ADDR_W'($urandom);
      xa  = ADDR_W'($urandom);
      oa  = ADDR_W'($urandom);
      len = LEN_W'($urandom_range(0, 12));
      load_vec(wa, int'(len), 1'b1, 16'd0);
      load_vec(xa, int'(len), 1'b1, 16'd0);
      run_cmd($sformatf("rnd%0d", t), wa, xa, oa, len);
    end

    @(negedge clk);
    #2;
    check("strobe_rules", 32'(n_bad), 32'd0);
    check("ready_while_busy", 32'(n_ready_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tiny_dnn_mac_seq.md
TINY_DNN_MAC_SEQ -- requirements
Module: tiny_dnn_mac_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word address width of the shared 16-bit RAM (8192 words).
REQ-002 SHALL have parameter LEN_W, default 10, width of the element-count field.
REQ-003 SHALL have parameter SHIFT, default 0, right shift applied to the accumulator before write-back (range 0..16).
REQ-004 S_AXI_ACLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 S_AXI_ARESETN  in  1  reset, asynchronous and active-low.
REQ-006 cmd_valid  in  1  host command request.
REQ-007 cmd_ready  out  1  command accepted on the edge where cmd_valid&cmd_ready.
REQ-008 cmd_waddr  in  ADDR_W  weight vector base address.
REQ-009 cmd_xaddr  in  ADDR_W  activation vector base address.
REQ-010 cmd_oaddr  in  ADDR_W  result word address.
REQ-011 cmd_len  in  LEN_W  element count (0 legal).
REQ-012 host_req  in  1  AXI-side request for the RAM port.
REQ-013 host_gnt  out  1  AXI side owns the RAM port this cycle.
REQ-014 ram_re  out  1  sequencer read strobe.
REQ-015 ram_addr  out  ADDR_W  sequencer read/write address.
REQ-016 ram_rdata  in  16  read data, valid the cycle after ram_re.
REQ-017 ram_we  out  1  sequencer write strobe.
REQ-018 ram_wdata  out  16  write-back data.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 result  out  32  last full accumulator value, held until the next completion.

Function
- REQ-022 States: IDLE, RD_W, RD_X, MAC, WRITE.
- REQ-023 IDLE: cmd_ready=1.
  - On accept, latch all cmd fields, clear acc and index i, and go to RD_W.
  - If cmd_len==0, go directly to WRITE instead.
- REQ-024 RD_W: ram_re=1, ram_addr=waddr+i; next state RD_X.
- REQ-025 RD_X: ram_re=1, ram_addr=xaddr+i; register ram_rdata as w; next state MAC.
- REQ-026 MAC: acc <= acc + w*ram_rdata.
  - Operands are 16-bit unsigned; the product is 32-bit.
  - acc is 32-bit and wraps modulo 2^32.
  - i <= i+1.
  - Next state is WRITE if i==len-1, else RD_W.
- REQ-027 WRITE:
  - ram_we=1, ram_addr=oaddr, ram_wdata=(acc>>SHIFT)[15:0], done=1.
  - result<=acc.
  - Next state IDLE.
- REQ-028 Latency from the accept edge to done high is 3*len+1 cycles (len=0: 1 cycle).
- REQ-029 Address sums wrap modulo 2^ADDR_W with no error.
- REQ-030 cmd_ready=0 whenever busy; commands presented while busy are neither lost nor latched and stay pending until IDLE.
- REQ-031 host_gnt=host_req&(state==IDLE).
  - When cmd_valid and host_req are both high in IDLE, the host wins: cmd_ready=0 that cycle.
- REQ-032 ram_re and ram_we are never high together; both are 0 whenever host_gnt=1.
- REQ-033 cmd_* inputs may change after accept without affecting the operation in flight.

Reset
- REQ-034 Reset asserted (any time, including mid-operation):
  - state=IDLE; acc, i, w, result = 0.
  - busy, done, ram_re, ram_we = 0.
  - No write-back occurs for the aborted operation.
- REQ-035 Release is synchronized to the clock only through normal flop recovery; the first accept is possible on the first edge after deassertion.

Structure
- REQ-036 Package tiny_dnn_pkg SHALL hold the state enum, the RAM data width (16), the accumulator width (32), and the ADDR_W default.
- REQ-037 The 16x16 multiply-accumulate SHALL be one sub-module, tiny_dnn_mac (inputs w, x, en, clr; output acc); the FSM and address generation stay in tiny_dnn_mac_seq.

Verification
- REQ-038 len=3, W={1,2,3}@0x010, X={4,5,6}@0x020, oaddr=0x030:
  - Expect ram_wdata=32 at 0x030, result=32.
  - done exactly 10 cycles after accept.
- REQ-039 len=0: WRITE of 0 to oaddr, done 1 cycle after accept, no ram_re ever asserted.
- REQ-040 W=X=0xFFFF, len=2, SHIFT=0:
  - result=0xFFFC0002 (32-bit wrap), ram_wdata=0x0002.
  - Repeat with SHIFT=16: ram_wdata=0xFFFC.
- REQ-041 waddr=0x1FFF, len=2: second weight read at address 0x0000.
- REQ-042 Contention:
  - host_req and cmd_valid together in IDLE: host_gnt=1, cmd_ready=0.
  - host_req during busy: host_gnt=0 until IDLE.
  - Second cmd_valid during busy accepted only after done.
- REQ-043 Reset asserted in MAC of a len=4 operation:
  - Outputs clear immediately (async); no ram_we.
  - A new command after release completes normally.
